// File: rtl/weight_bank_loader.sv
// Runtime loader for the per-layer CNN weight banks.
// A single valid/ready stream is scattered round-robin over NUM banks: word k
// lands in bank k mod NUM at address k / NUM, matching the per-bank .mem image
// layout. All banks are read combinationally through one shared address.
module weight_bank_loader #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ADDR  = 7,
  parameter int unsigned NUM   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          busy,
  output logic                          load_done,
  output logic [ADDR+$clog2(NUM)-1:0]   words_loaded,
  input  logic [ADDR-1:0]               address,
  output logic [WIDTH-1:0]              rom_out [0:NUM-1]
);

  localparam int unsigned SelW  = $clog2(NUM);
  localparam int unsigned CntW  = ADDR + SelW;
  localparam int unsigned Depth = 2 ** ADDR;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              wr_en;
  logic [SelW-1:0]   bank_sel;
  logic [ADDR-1:0]   bank_addr;

  // Handshake: wr_ready is high exactly while loading, so it doubles as the
  // write qualifier.
  assign wr_en     = wr_valid && wr_ready;
  assign bank_sel  = cnt_q[SelW-1:0];
  assign bank_addr = cnt_q[CntW-1:SelW];

  // Load sequencer with registered handshake and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wr_ready  <= 1'b0;
      busy      <= 1'b0;
      load_done <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StLoad;
            cnt_q    <= '0;
            wr_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        StLoad: begin
          // start is deliberately not looked at here: a load always runs to
          // completion unless reset.
          if (wr_en) begin
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == {CntW{1'b1}}) begin
              state_q   <= StDone;
              wr_ready  <= 1'b0;
              busy      <= 1'b0;
              load_done <= 1'b1;
            end
          end
        end
        StDone: begin
          if (start) begin
            state_q   <= StLoad;
            cnt_q     <= '0;
            wr_ready  <= 1'b1;
            busy      <= 1'b1;
            load_done <= 1'b0;
          end
        end
        default: begin
          state_q  <= StIdle;
          wr_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Progress report: live count while loading, saturated all-ones once done.
  always_comb begin
    words_loaded = '0;
    case (state_q)
      StLoad:  words_loaded = cnt_q;
      StDone:  words_loaded = '1;
      default: words_loaded = '0;
    endcase
  end

  // One distributed-RAM bank per output channel; contents survive reset.
  for (genvar b = 0; b < NUM; b++) begin : g_bank
    (* rom_style = "distributed" *) logic [WIDTH-1:0] mem [0:Depth-1];

    // Write the bank when the current word is routed to it.
    always_ff @(posedge clk) begin
      if (wr_en && (bank_sel == SelW'(b))) begin
        mem[bank_addr] <= wr_data;
      end
    end

    assign rom_out[b] = mem[address];
  end

endmodule

// File: tb/tb_weight_bank_loader.sv
// Directed bench for weight_bank_loader with default parameters (1024 words).
module tb_weight_bank_loader;

  localparam int WIDTH = 32;
  localparam int ADDR  = 7;
  localparam int NUM   = 8;
  localparam int TOTAL = NUM * (2 ** ADDR);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic             busy;
  logic             load_done;
  logic [9:0]       words_loaded;
  logic [ADDR-1:0]  address;
  logic [WIDTH-1:0] rom_out [0:NUM-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  weight_bank_loader #(
    .WIDTH(WIDTH),
    .ADDR (ADDR),
    .NUM  (NUM)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .busy        (busy),
    .load_done   (load_done),
    .words_loaded(words_loaded),
    .address     (address),
    .rom_out     (rom_out)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Every bank/address must hold base + interleaved word index.
  task automatic check_contents(input logic [WIDTH-1:0] base, input string name);
    logic [WIDTH-1:0] exp;
    for (int a = 0; a < 2 ** ADDR; a++) begin
      address = ADDR'(a);
      #1;
      for (int b = 0; b < NUM; b++) begin
        exp = base + WIDTH'(a * NUM + b);
        checks++;
        if (rom_out[b] !== exp) begin
          errors++;
          $display("FAIL %s addr=%0d bank=%0d got=%h want=%h", name, a, b, rom_out[b], exp);
        end
      end
    end
  endtask

  // Start a load and stream words base+k. Optional start pulse at a given
  // count and optional reset abort at a given count (-1 disables each).
  task automatic run_load(input logic [WIDTH-1:0] base, input bit rand_valid,
                          input int start_at, input int rst_at, input string name);
    int xfers;
    int cycles;
    bit v;
    pulse_start();
    checks++;
    if ({wr_ready, busy, load_done} !== 3'b110) begin
      errors++;
      $display("FAIL %s_start_flags got=%b want=110", name, {wr_ready, busy, load_done});
    end
    xfers  = 0;
    cycles = 0;
    while (xfers < TOTAL && cycles < 6000) begin
      v        = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_valid = v;
      wr_data  = base + WIDTH'(xfers);
      start    = (xfers == start_at);
      checks++;
      if (words_loaded !== 10'(xfers) || load_done !== 1'b0 || wr_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s_progress got cnt=%0d done=%b rdy=%b want cnt=%0d done=0 rdy=1",
                 name, words_loaded, load_done, wr_ready, xfers);
      end
      if (xfers == rst_at) begin
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        start    = 1'b0;
        checks++;
        if ({wr_ready, busy, load_done} !== 3'b000 || words_loaded !== 10'd0) begin
          errors++;
          $display("FAIL %s_abort got flags=%b cnt=%0d want flags=000 cnt=0",
                   name, {wr_ready, busy, load_done}, words_loaded);
        end
        return;
      end
      tick();
      cycles++;
      if (v) xfers++;
    end
    wr_valid = 1'b0;
    start    = 1'b0;
    checks++;
    if (xfers != TOTAL) begin
      errors++;
      $display("FAIL %s_timeout got xfers=%0d want %0d", name, xfers, TOTAL);
    end
    checks++;
    if ({wr_ready, busy, load_done} !== 3'b001 || words_loaded !== 10'h3FF) begin
      errors++;
      $display("FAIL %s_done got flags=%b cnt=%0d want flags=001 cnt=1023",
               name, {wr_ready, busy, load_done}, words_loaded);
    end
    tick();
    checks++;
    if ({wr_ready, busy, load_done} !== 3'b001) begin
      errors++;
      $display("FAIL %s_sticky got flags=%b want 001", name, {wr_ready, busy, load_done});
    end
  endtask

  task automatic test_reset();
    // Reset and start in the same cycle: reset wins.
    rst_n    = 1'b0;
    start    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 32'h0000_1234;
    tick();
    tick();
    checks++;
    if ({wr_ready, busy, load_done} !== 3'b000 || words_loaded !== 10'd0) begin
      errors++;
      $display("FAIL reset got flags=%b cnt=%0d want flags=000 cnt=0",
               {wr_ready, busy, load_done}, words_loaded);
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if ({wr_ready, busy, load_done} !== 3'b000 || words_loaded !== 10'd0) begin
        errors++;
        $display("FAIL idle_valid cyc=%0d got flags=%b cnt=%0d want flags=000 cnt=0",
                 i, {wr_ready, busy, load_done}, words_loaded);
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_full_stream();
    run_load(32'd0, 1'b0, -1, -1, "full");
    check_contents(32'd0, "full_data");
  endtask

  // In DONE, valid words must be refused and the banks left alone.
  task automatic test_done_ignores_valid();
    wr_valid = 1'b1;
    wr_data  = 32'hBAD0_BAD0;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if ({wr_ready, busy, load_done} !== 3'b001 || words_loaded !== 10'h3FF) begin
        errors++;
        $display("FAIL done_valid cyc=%0d got flags=%b cnt=%0d want flags=001 cnt=1023",
                 i, {wr_ready, busy, load_done}, words_loaded);
      end
    end
    wr_valid = 1'b0;
    check_contents(32'd0, "done_keep");
  endtask

  task automatic test_start_during_load();
    run_load(32'd8192, 1'b0, 300, -1, "restart");
    check_contents(32'd8192, "restart_data");
  endtask

  // Random valid, plus a start pulse coinciding with the last transfer.
  task automatic test_random_valid();
    run_load(32'd0, 1'b1, TOTAL - 1, -1, "random");
    check_contents(32'd0, "random_data");
  endtask

  task automatic test_reset_abort();
    run_load(32'd4096, 1'b0, -1, 500, "abort");
    run_load(32'd4096, 1'b0, -1, -1, "reload");
    check_contents(32'd4096, "reload_data");
  endtask

  task automatic test_back_to_back_single();
    pulse_start();
    checks++;
    if (load_done !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_start got done=%b rdy=%b want done=0 rdy=1", load_done, wr_ready);
    end
    wr_valid = 1'b1;
    wr_data  = 32'hDEAD_BEEF;
    address  = '0;
    tick();
    wr_valid = 1'b0;
    checks++;
    if (rom_out[0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_bank0 got=%h want=deadbeef", rom_out[0]);
    end
    checks++;
    if (rom_out[1] !== 32'd4097) begin
      errors++;
      $display("FAIL single_bank1 got=%h want=%h", rom_out[1], 32'd4097);
    end
    checks++;
    if (words_loaded !== 10'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_count got cnt=%0d busy=%b want cnt=1 busy=1", words_loaded, busy);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    address  = '0;
    test_reset();
    test_full_stream();
    test_done_ignores_valid();
    test_start_during_load();
    test_random_valid();
    test_reset_abort();
    test_back_to_back_single();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
